piso_shift_tx: RTL and testbench

//  Parallel-in/serial-out transmitter: the send side of the team's 8-stage serial-in shift register.

---
 rtl/piso_tx_pkg.sv | 28 ++
 rtl/piso_bit_cnt.sv | 43 ++++
 rtl/piso_shift_tx.sv | 177 +++++++++++++++++
 tb/tb_piso_shift_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Package piso_tx_pkg
//   Shared types and sizing helpers for the parallel-in/serial-out transmitter.
//   - state_t   : transmitter FSM states (IDLE, SHIFT)
//   - nbits_f   : number of bits sent per word (W, or W+1 with parity)
//   - cnt_w_f   : bit counter width, $clog2(W+1)
//   Optional feature macro: PISO_TX_PARITY_EN (appends one even-parity bit).
package piso_tx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits sent per word; the parity build adds one trailing bit.
  function automatic int nbits_f(input int w);
`ifdef PISO_TX_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  // Counter width wide enough to hold W (index of the parity bit).
  function automatic int cnt_w_f(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Module piso_bit_cnt
//   Bit position counter for the serial transmitter.
//   Ports:
//     clk  in   clock, rising edge
//     rst  in   synchronous active-high reset (counter to 0)
//     clr  in   synchronous clear to 0 (priority over en)
//     en   in   increment by one
//     cnt  out  current bit index
//     tc   out  terminal count flag, high when cnt == NBITS-1
module piso_bit_cnt #(
  parameter int NBITS = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL  = CW'(NBITS - 1);
  localparam logic [CW-1:0] ONE_VAL = CW'(1);

  logic [CW-1:0] cnt_r;

  // Counter register: clear wins over increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + ONE_VAL;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == TC_VAL);

endmodule

// File: rtl/piso_shift_tx.sv
// Module piso_shift_tx
//   Parallel-in/serial-out transmitter feeding a downstream SIPO chain that is
//   clocked by the same shift_en tick. A word is taken over a valid/ready
//   handshake while idle and then shifted out one bit per tick.
//   Ports:
//     clk         in   clock, all state on rising edge
//     rst         in   synchronous active-high reset, overrides everything
//     load_valid  in   load_data is offered
//     load_ready  out  high only while idle
//     load_data   in   W-bit word, sampled on load_valid & load_ready
//     shift_en    in   bit-rate tick, advances one bit while shifting
//     sout        out  serial data (0 when idle)
//     busy        out  high while shifting
//     done        out  one-cycle pulse after the last bit is consumed
//   Parameters: W (word width, >= 2), MSB_FIRST (1: bit W-1 first).
//   Optional feature macro: PISO_TX_PARITY_EN -- sends an even-parity bit
//   after the W data bits; done then follows the parity bit.
module piso_shift_tx
  import piso_tx_pkg::*;
#(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int NBITS = nbits_f(W);
  localparam int CW    = cnt_w_f(W);

  // Even parity of a captured word.
  function automatic logic even_parity_f(input logic [W-1:0] d);
    return ^d;
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [W-1:0]  shreg_r;
  logic [W-1:0]  shifted_s;
  logic          done_r;
  logic          done_nxt_s;
  logic          load_s;
  logic          shift_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic [CW-1:0] cnt_s;
  logic          tc_s;
  logic          out_bit_s;
  logic          sout_s;

  // Only the handshake can start a word; load_valid while shifting is ignored.
  assign load_s = load_valid && (state_r == IDLE);

  // Move the register toward the output end with zero fill.
  assign shifted_s = (MSB_FIRST != 0) ? {shreg_r[W-2:0], 1'b0}
                                      : {1'b0, shreg_r[W-1:1]};
  assign out_bit_s = (MSB_FIRST != 0) ? shreg_r[W-1] : shreg_r[0];

  piso_bit_cnt #(
    .NBITS (NBITS),
    .CW    (CW)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_s),
    .tc  (tc_s)
  );

  // Next-state and control decode; a tick arriving with a load in IDLE is dropped.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_nxt_s = SHIFT;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (tc_s) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            cnt_en_s = 1'b1;
            shift_s  = 1'b1;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, shift register and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
      if (load_s) begin
        shreg_r <= load_data;
      end else if (shift_s) begin
        shreg_r <= shifted_s;
      end else begin
        shreg_r <= shreg_r;
      end
    end
  end

`ifdef PISO_TX_PARITY_EN
  localparam logic [CW-1:0] PAR_IDX = CW'(W);
  logic par_r;

  // Parity is frozen at transfer time so it survives the data shifting out.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_r <= 1'b0;
    end else if (load_s) begin
      par_r <= even_parity_f(load_data);
    end else begin
      par_r <= par_r;
    end
  end

  // Serial output decode: parity slot follows the last data bit.
  always_comb begin
    sout_s = 1'b0;
    if (state_r == SHIFT) begin
      if (cnt_s == PAR_IDX) begin
        sout_s = par_r;
      end else begin
        sout_s = out_bit_s;
      end
    end else begin
      sout_s = 1'b0;
    end
  end
`else
  // Serial output decode from registers only.
  always_comb begin
    sout_s = 1'b0;
    if (state_r == SHIFT) begin
      sout_s = out_bit_s;
    end else begin
      sout_s = 1'b0;
    end
  end
`endif

  assign sout       = sout_s;
  assign busy       = (state_r == SHIFT);
  assign load_ready = (state_r == IDLE);
  assign done       = done_r;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: MSB-first instance plus an LSB-first instance.
// Inputs are driven and outputs sampled on the falling edge.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid, load_ready, shift_en, sout, busy, done;
  logic [W-1:0] load_data;
  logic         l_valid, l_ready, l_shift_en, l_sout, l_busy, l_done;
  logic [W-1:0] l_data;
  logic [7:0]   sipo_m;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.W(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .shift_en(shift_en), .sout(sout), .busy(busy), .done(done)
  );

  piso_shift_tx #(.W(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(l_valid), .load_ready(l_ready),
    .load_data(l_data), .shift_en(l_shift_en), .sout(l_sout), .busy(l_busy), .done(l_done)
  );

  // Downstream 8-stage SIPO model clocked by the tick.
  always @(posedge clk) begin
    if (shift_en) sipo_m <= {sipo_m[6:0], sout};
  end

  // Reference: bit i of the serial frame for word w.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; shift_en = 1'b1;
    l_valid = 1'b0; l_data = '0; l_shift_en = 1'b0;
    repeat (3) @(negedge clk);
    obs = {sout, busy, done, load_ready};
    checks++;
    if (obs !== 4'b0001) begin
      errs++; $display("FAIL reset {sout,busy,done,ready}: got %b exp %b", obs, 4'b0001);
    end
    rst = 1'b0; shift_en = 1'b0;
    @(negedge clk);
    obs = {sout, busy, done, load_ready};
    checks++;
    if (obs !== 4'b0001) begin
      errs++; $display("FAIL idle_after_reset: got %b exp %b", obs, 4'b0001);
    end
  endtask

  // Word with shift_en tied high, including a tick coincident with the load.
  task automatic test_msb_first(input logic [W-1:0] w);
    logic [3:0] obs, exp;
    load_valid = 1'b1; load_data = w; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; load_data = $urandom;
    for (int i = 0; i < NB; i++) begin
      obs = {sout, busy, done, load_ready}; exp = {exp_bit(w, i, 1'b1), 3'b100};
      checks++;
      if (obs !== exp) begin
        errs++; $display("FAIL msb_first w=%h bit%0d: got %b exp %b", w, i, obs, exp);
      end
      @(negedge clk);
    end
    obs = {sout, busy, done, load_ready};
    checks++;
    if (obs !== 4'b0011) begin
      errs++; $display("FAIL msb_first_done w=%h: got %b exp %b", w, obs, 4'b0011);
    end
    shift_en = 1'b0;
    @(negedge clk);
    obs = {sout, busy, done, load_ready};
    checks++;
    if (obs !== 4'b0001) begin
      errs++; $display("FAIL msb_first_done_pulse w=%h: got %b exp %b", w, obs, 4'b0001);
    end
  endtask

  // Tick every per-th cycle; optionally keep offering a junk word while shifting.
  task automatic test_slow_tick(input logic [W-1:0] w, input int per, input bit hold);
    logic [3:0] obs, exp;
    load_valid = 1'b1; load_data = w; shift_en = 1'b0;
    @(negedge clk);
    load_valid = hold; load_data = 8'hFF;
    for (int i = 0; i < NB; i++) begin
      for (int k = 0; k < per; k++) begin
        obs = {sout, busy, done, load_ready}; exp = {exp_bit(w, i, 1'b1), 3'b100};
        checks++;
        if (obs !== exp) begin
          errs++; $display("FAIL slow_tick w=%h bit%0d cyc%0d: got %b exp %b", w, i, k, obs, exp);
        end
        shift_en = (k == per - 1);
        if (i == NB - 1 && k == per - 1) load_valid = 1'b0;
        @(negedge clk);
      end
    end
    shift_en = 1'b0;
    obs = {sout, busy, done, load_ready};
    checks++;
    if (obs !== 4'b0011) begin
      errs++; $display("FAIL slow_tick_done w=%h: got %b exp %b", w, obs, 4'b0011);
    end
    @(negedge clk);
  endtask

  // Random tick pattern; the model advances its bit index on each tick.
  task automatic test_random_ticks(input int n);
    logic [3:0] obs, exp;
    logic [W-1:0] w;
    int idx, cyc;
    for (int t = 0; t < n; t++) begin
      w = $urandom;
      load_valid = 1'b1; load_data = w; shift_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      load_valid = 1'($urandom_range(0, 1)); load_data = $urandom;
      idx = 0; cyc = 0;
      while (idx < NB && cyc < 400) begin
        obs = {sout, busy, done, load_ready}; exp = {exp_bit(w, idx, 1'b1), 3'b100};
        checks++;
        if (obs !== exp) begin
          errs++; $display("FAIL random w=%h bit%0d: got %b exp %b", w, idx, obs, exp);
        end
        shift_en = 1'($urandom_range(0, 1));
        if (idx == NB - 1 && shift_en) load_valid = 1'b0;
        @(negedge clk);
        if (shift_en) idx++;
        cyc++;
      end
      checks++;
      if (idx < NB) begin
        errs++; $display("FAIL random_timeout: got idx %0d exp %0d", idx, NB);
      end
      shift_en = 1'b0; load_valid = 1'b0;
      obs = {sout, busy, done, load_ready};
      checks++;
      if (obs !== 4'b0011) begin
        errs++; $display("FAIL random_done w=%h: got %b exp %b", w, obs, 4'b0011);
      end
      @(negedge clk);
    end
  endtask

  // Reset after the 3rd bit abandons the word; then a clean word follows.
  task automatic test_reset_mid();
    logic [3:0] obs;
    load_valid = 1'b1; load_data = 8'hC3; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs = {sout, busy, done, load_ready};
    checks++;
    if (obs !== 4'b0001) begin
      errs++; $display("FAIL reset_mid: got %b exp %b", obs, 4'b0001);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errs++; $display("FAIL reset_mid_no_done: got %b exp %b", done, 1'b0);
    end
    test_msb_first(8'h3C);
  endtask

  // Back-to-back random words on done, checked through the SIPO model.
  task automatic test_loopback(input int n);
    logic [W-1:0] words[4];
    logic [7:0]   exp_sipo;
    logic [3:0]   obs, exp;
    for (int j = 0; j < n; j++) words[j] = $urandom;
    shift_en = 1'b1; load_valid = 1'b1; load_data = words[0];
    @(negedge clk);
    load_valid = 1'b0;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < NB; i++) begin
        obs = {sout, busy, done, load_ready}; exp = {exp_bit(words[j], i, 1'b1), 3'b100};
        checks++;
        if (obs !== exp) begin
          errs++; $display("FAIL b2b word%0d bit%0d: got %b exp %b", j, i, obs, exp);
        end
        @(negedge clk);
      end
      for (int s = 0; s < 8; s++) exp_sipo[7-s] = exp_bit(words[j], NB - 8 + s, 1'b1);
      checks++;
      if (done !== 1'b1 || sipo_m !== exp_sipo) begin
        errs++; $display("FAIL b2b_sipo word%0d: got done=%b sipo=%h exp done=1 sipo=%h",
                         j, done, sipo_m, exp_sipo);
      end
      if (j < n - 1) begin
        load_valid = 1'b1; load_data = words[j+1];
      end else begin
        shift_en = 1'b0;
      end
      @(negedge clk);
      load_valid = 1'b0;
    end
  endtask

  // LSB-first instance: 8'h01 gives 1 then zeros.
  task automatic test_lsb_first(input logic [W-1:0] w);
    logic [3:0] obs, exp;
    l_valid = 1'b1; l_data = w; l_shift_en = 1'b1;
    @(negedge clk);
    l_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      obs = {l_sout, l_busy, l_done, l_ready}; exp = {exp_bit(w, i, 1'b0), 3'b100};
      checks++;
      if (obs !== exp) begin
        errs++; $display("FAIL lsb_first w=%h bit%0d: got %b exp %b", w, i, obs, exp);
      end
      @(negedge clk);
    end
    obs = {l_sout, l_busy, l_done, l_ready};
    checks++;
    if (obs !== 4'b0011) begin
      errs++; $display("FAIL lsb_first_done: got %b exp %b", obs, 4'b0011);
    end
    l_shift_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_msb_first(8'hA5);
    test_slow_tick(8'h81, 3, 1'b0);
    test_slow_tick(8'h0F, 1, 1'b1);
    test_reset_mid();
    test_loopback(4);
    test_random_ticks(6);
`ifdef PISO_TX_PARITY_EN
    test_msb_first(8'h07);
    test_msb_first(8'h03);
`endif
    test_lsb_first(8'h01);
    test_lsb_first(8'h6D);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
